pipe_rx_cmd: RTL and testbench

Host-to-accelerator command receiver. It takes 32-bit words from the USB pipe-in path, the direction opposite to the `usb` result uploader. It frames them into command packets, checks each packet's XOR checksum, and buffers one packet at a time. Validated packets are forwarded on a valid/ready stream toward `csb`, which dispatches them to the conv, pool and dma cores.

---
 rtl/pipe_rx_cmd_if.sv | 27 ++
 rtl/pipe_rx_cmd.sv | 113 +++++++++++
 tb/tb_pipe_rx_cmd.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_rx_cmd_if.sv
// Host pipe-in command stream and forwarded packet stream for pipe_rx_cmd.
// The master side drives host words and downstream ready; the slave side is the receiver.
interface pipe_rx_cmd_if #(
    parameter int unsigned DW = 32
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_ready;
    logic          pkt_ok;
    logic          pkt_err;
    logic [7:0]    err_cnt;
    logic          busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, pkt_ok, pkt_err, err_cnt, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, pkt_ok, pkt_err, err_cnt, busy
    );
endinterface

// File: rtl/pipe_rx_cmd.sv
// Frames host words into command packets, validates the XOR checksum and
// forwards one buffered packet at a time (header first, then payload).
module pipe_rx_cmd #(
    parameter int unsigned DW      = 32,
    parameter int unsigned MAX_LEN = 8
) (
    input logic          clk,
    input logic          reset,
    pipe_rx_cmd_if.slave bus
);
    localparam int unsigned IW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned DEPTH = 1 << IW;

    typedef enum logic [1:0] {HDR, PLD, CSUM, SEND} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] hdr, xor_acc, out_data_r;
    logic [DW-1:0] pld_buf [DEPTH];
    logic [7:0]    idx, ptr, err_cnt_r;
    logic          out_last_r, pkt_ok_r, pkt_err_r, busy_r;
    logic          in_ready, out_valid, in_fire, out_fire;
    logic          hdr_legal, csum_match, err_evt;
    logic [7:0]    hdr_len;

    assign hdr_len = hdr[23:16];

    always_comb begin
        in_ready   = (state != SEND);
        out_valid  = (state == SEND);
        in_fire    = bus.in_valid && in_ready;
        out_fire   = out_valid && bus.out_ready;
        hdr_legal  = (bus.in_data[31:24] != '0) && (bus.in_data[23:16] <= 8'(MAX_LEN));
        csum_match = (bus.in_data == xor_acc);
        err_evt    = in_fire && (((state == HDR) && !hdr_legal) ||
                                 ((state == CSUM) && !csum_match));
        state_nxt  = state;
        case (state)
            HDR:  if (in_fire && hdr_legal)
                      state_nxt = (bus.in_data[23:16] == '0) ? CSUM : PLD;
            PLD:  if (in_fire && (idx + 8'd1 == hdr_len)) state_nxt = CSUM;
            CSUM: if (in_fire) state_nxt = csum_match ? SEND : HDR;
            SEND: if (out_fire && out_last_r) state_nxt = HDR;
            default: state_nxt = HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= HDR;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (state == PLD && in_fire) pld_buf[idx[IW-1:0]] <= bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hdr        <= '0;
            xor_acc    <= '0;
            idx        <= '0;
            ptr        <= '0;
            out_data_r <= '0;
            out_last_r <= 1'b0;
            pkt_ok_r   <= 1'b0;
            pkt_err_r  <= 1'b0;
            err_cnt_r  <= '0;
            busy_r     <= 1'b0;
        end else begin
            pkt_ok_r  <= 1'b0;
            pkt_err_r <= err_evt;
            busy_r    <= (state_nxt != HDR);
            if (err_evt && err_cnt_r != '1) err_cnt_r <= err_cnt_r + 8'd1;
            case (state)
                HDR: if (in_fire) begin
                    hdr     <= bus.in_data;
                    xor_acc <= bus.in_data;
                    idx     <= '0;
                end
                PLD: if (in_fire) begin
                    xor_acc <= xor_acc ^ bus.in_data;
                    idx     <= idx + 8'd1;
                end
                CSUM: if (in_fire && csum_match) begin
                    pkt_ok_r   <= 1'b1;
                    out_data_r <= hdr;
                    out_last_r <= (hdr_len == '0);
                    ptr        <= '0;
                end
                SEND: if (out_fire) begin
                    // ptr indexes the payload word to present after the current one
                    if (out_last_r) begin
                        out_data_r <= '0;
                        out_last_r <= 1'b0;
                    end else begin
                        out_data_r <= pld_buf[ptr[IW-1:0]];
                        out_last_r <= (ptr + 8'd1 == hdr_len);
                        ptr        <= ptr + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data_r;
    assign bus.out_last  = out_last_r;
    assign bus.pkt_ok    = pkt_ok_r;
    assign bus.pkt_err   = pkt_err_r;
    assign bus.err_cnt   = err_cnt_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_pipe_rx_cmd.sv
// Directed bench for pipe_rx_cmd: packets, checksum/header rejects,
// back-pressure, reset mid-packet and error-counter saturation.
module tb_pipe_rx_cmd;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_rx_cmd_if #(.DW(32)) bus ();
    pipe_rx_cmd #(.DW(32), .MAX_LEN(8)) dut (.clk(clk), .reset(reset), .bus(bus));

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    int unsigned ok_pulses = 0;
    int unsigned err_pulses = 0;
    logic [32:0] outq [$];
    logic        bp_mode = 1'b0;
    logic        prev_stall = 1'b0;
    logic [32:0] prev_word = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Outputs sampled on the falling edge, where they are stable.
    always @(negedge clk) begin
        if (bus.pkt_ok)  ok_pulses++;
        if (bus.pkt_err) err_pulses++;
        if (prev_stall && bus.out_valid)
            check("stall_hold", {bus.out_last, bus.out_data}, prev_word);
        if (bp_mode && bus.out_valid) check("in_ready_send", bus.in_ready, 0);
        if (bus.out_valid && bus.out_ready) outq.push_back({bus.out_last, bus.out_data});
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_word  = {bus.out_last, bus.out_data};
    end

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        int unsigned n = 0;
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 100) begin
            tick(1);
            n++;
        end
        if (!bus.in_ready) check("in_ready_wait", bus.in_ready, 1);
        tick(1);
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic clear_mon();
        outq.delete();
        ok_pulses  = 0;
        err_pulses = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        check("rst_in_ready",  bus.in_ready,  1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data",  bus.out_data,  0);
        check("rst_out_last",  bus.out_last,  0);
        check("rst_pkt_ok",    bus.pkt_ok,    0);
        check("rst_pkt_err",   bus.pkt_err,   0);
        check("rst_err_cnt",   bus.err_cnt,   0);
        check("rst_busy",      bus.busy,      0);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic check_q(input string tag, input int unsigned idx, input logic [32:0] exp);
        logic [32:0] got;
        got = (idx < outq.size()) ? outq[idx] : '1;
        check(tag, got, exp);
    endtask

    logic [31:0] nom [4];
    logic [32:0] nom_out [3];
    int unsigned gaps [4];
    logic [15:0] rdy_pat;

    initial begin
        nom     = '{32'h01020005, 32'h11111111, 32'h22222222, 32'h32313336};
        nom_out = '{{1'b0, 32'h01020005}, {1'b0, 32'h11111111}, {1'b1, 32'h22222222}};
        gaps    = '{2, 0, 1, 3};
        rdy_pat = 16'b1011_0100_1100_1000;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        reset         = 1'b1;
        tick(2);
        do_reset();

        // Nominal packet, including first-word latency after the checksum
        clear_mon();
        for (int i = 0; i < 4; i++) send_word(nom[i]);
        check("lat_out_valid", bus.out_valid, 1);
        check("lat_out_data",  bus.out_data,  32'h01020005);
        check("lat_pkt_ok",    bus.pkt_ok,    1);
        tick(8);
        check("nom_ok_pulses", ok_pulses, 1);
        check("nom_count",     outq.size(), 3);
        for (int i = 0; i < 3; i++) check_q("nom_word", i, nom_out[i]);
        check("nom_in_ready",  bus.in_ready, 1);
        check("nom_busy",      bus.busy, 0);

        // Zero-length packet
        clear_mon();
        send_word(32'h03000007);
        send_word(32'h03000007);
        tick(6);
        check("zl_count", outq.size(), 1);
        check_q("zl_word", 0, {1'b1, 32'h03000007});

        // Bad checksum, then a good packet
        clear_mon();
        for (int i = 0; i < 3; i++) send_word(nom[i]);
        send_word(32'h32313337);
        check("bad_pkt_err",   bus.pkt_err, 1);
        tick(1);
        check("bad_err_once",  bus.pkt_err, 0);
        tick(5);
        check("bad_err_cnt",   bus.err_cnt, 1);
        check("bad_no_out",    outq.size(), 0);
        check("bad_no_ok",     ok_pulses, 0);
        for (int i = 0; i < 4; i++) send_word(nom[i]);
        tick(8);
        check("after_bad_cnt", outq.size(), 3);
        for (int i = 0; i < 3; i++) check_q("after_bad_word", i, nom_out[i]);

        // Illegal headers from a fresh count
        do_reset();
        clear_mon();
        send_word(32'h00010000);
        check("op0_pkt_err", bus.pkt_err, 1);
        check("op0_busy",    bus.busy, 0);
        send_word(32'h01090000);
        check("len9_pkt_err", bus.pkt_err, 1);
        check("len9_busy",    bus.busy, 0);
        tick(3);
        check("ill_err_cnt",   bus.err_cnt, 2);
        check("ill_err_pulse", err_pulses, 2);
        check("ill_no_out",    outq.size(), 0);

        // Back-pressure with input gaps
        clear_mon();
        bp_mode = 1'b1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(gaps[i]);
            send_word(nom[i]);
            if (i < 3) check("bp_busy", bus.busy, 1);
        end
        for (int i = 0; i < 40; i++) begin
            bus.out_ready = rdy_pat[i % 16];
            tick(1);
            if (outq.size() == 3 && !bus.out_valid) break;
        end
        bp_mode = 1'b0;
        bus.out_ready = 1'b1;
        tick(2);
        check("bp_count", outq.size(), 3);
        for (int i = 0; i < 3; i++) check_q("bp_word", i, nom_out[i]);
        check("bp_in_ready", bus.in_ready, 1);

        // Reset mid-packet, then a fresh packet
        clear_mon();
        send_word(32'h01020005);
        send_word(32'h11111111);
        do_reset();
        send_word(32'h05000009);
        send_word(32'h05000009);
        tick(6);
        check("rst_mid_count", outq.size(), 1);
        check_q("rst_mid_word", 0, {1'b1, 32'h05000009});

        // Error counter saturation
        clear_mon();
        for (int k = 0; k < 300; k++) begin
            send_word(32'h03000007);
            send_word(32'h00000000);
            if (k == 254) check("sat_reach", bus.err_cnt, 255);
            if (k == 299) check("sat_last_pulse", bus.pkt_err, 1);
        end
        tick(2);
        check("sat_hold",   bus.err_cnt, 255);
        check("sat_pulses", err_pulses, 300);
        check("sat_no_out", outq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
